rr_arbiter_4: RTL and testbench

Four-requester round-robin arbiter with a bounded grant-hold time, built on the 4-to-2 priority encoding used in the combinational encoder library. It shares a single downstream resource among four requesters. It issues a registered one-hot grant, an encoded grant index and an idle flag. It guarantees that no requester starves: the owner is forced to rotate out when it exceeds `MAX_HOLD` cycles while others wait.

---
 rtl/rr_arbiter_4.sv | 164 ++++++++++++++++
 tb/tb_rr_arbiter_4.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-requester round-robin arbiter with a bounded grant-hold time.
// A rotating priority pointer picks the next owner. Under contention the owner
// is forced out once it has held the grant for MAX_HOLD cycles. All outputs
// are registered, so there is no combinational path from req to any output.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8  // legal range 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       idle
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  // Two-state controller; a one-bit code keeps it readable in older flows.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // 4-to-2 priority encoder: index of the lowest set bit (0 when v is zero).
  function automatic logic [1:0] prio_enc4(input logic [3:0] v);
    logic [1:0] idx;
    casez (v)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Rotate right by s so that bit s of v lands at bit 0.
  function automatic logic [3:0] rotr4(input logic [3:0] v, input logic [1:0] s);
    return 4'({v, v} >> s);
  endfunction

  // 2-to-4 one-hot decoder.
  function automatic logic [3:0] dec4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       grant_idx_q, grant_idx_d;
  logic             grant_valid_q, grant_valid_d;
  logic             idle_q, idle_d;

  // ---------------------------------------------------------------------------
  // Arbitration datapath
  // ---------------------------------------------------------------------------
  logic       owner_req;     // current owner is still requesting
  logic       others_req;    // some requester other than the owner is waiting
  logic       hold_full;     // owner has used up its hold budget
  logic       release_own;   // owner gives up the grant this cycle
  logic [1:0] ptr_after;     // pointer that would follow a release
  logic [1:0] arb_ptr;       // pointer used by this cycle's arbitration
  logic [3:0] req_rot;
  logic       any_req;
  logic [1:0] winner;

  // Decide whether the owner releases and run the circular scan from the
  // pointer that will be in force after any release.
  always_comb begin
    owner_req   = |(req & dec4(grant_idx_q));
    others_req  = |(req & ~dec4(grant_idx_q));
    hold_full   = (hold_q == HOLD_MAX);
    release_own = (state_q == ST_GRANT) && (!owner_req || (hold_full && others_req));
    ptr_after   = grant_idx_q + 2'd1;
    arb_ptr     = release_own ? ptr_after : ptr_q;
    req_rot     = rotr4(req, arb_ptr);
    any_req     = |req;
    winner      = arb_ptr + prio_enc4(req_rot);
  end

  // Next-state and next-output logic for the two-state controller.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    grant_idx_d = grant_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          // Initial grant leaves the pointer untouched.
          state_d     = ST_GRANT;
          grant_idx_d = winner;
          hold_d      = HOLD_ONE;
        end
      end
      ST_GRANT: begin
        if (release_own) begin
          ptr_d = ptr_after;
          if (any_req) begin
            // Direct handoff, no idle gap.
            grant_idx_d = winner;
            hold_d      = HOLD_ONE;
          end else begin
            state_d     = ST_IDLE;
            grant_idx_d = 2'd0;
            hold_d      = '0;
          end
        end else if (!hold_full) begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        grant_idx_d = 2'd0;
        hold_d      = '0;
      end
    endcase

    grant_valid_d = (state_d == ST_GRANT);
    idle_d        = !grant_valid_d;
    grant_d       = grant_valid_d ? dec4(grant_idx_d) : 4'b0000;
  end

  // Register state and outputs; synchronous reset dominates everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= 2'd0;
      hold_q        <= '0;
      grant_q       <= 4'b0000;
      grant_idx_q   <= 2'd0;
      grant_valid_q <= 1'b0;
      idle_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_q        <= hold_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      idle_q        <= idle_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;
  assign idle        = idle_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: directed scenarios followed by random traffic.
// A behavioural model predicts the registered outputs for every cycle and
// pushes them into a scoreboard queue; a monitor pops and compares after
// each rising edge.
module tb_rr_arbiter_4;

  localparam int MH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       idle;

  rr_arbiter_4 #(.MAX_HOLD(MH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] idx;
    logic       v;
    logic       idl;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int m_owner = -1;  // -1 means no owner
  int m_ptr   = 0;
  int m_hold  = 0;

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (p + i) % 4;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] q);
    int  w;
    bit  others;
    bit  rel;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_hold = 0;
    end else if (m_owner < 0) begin
      w = first_from(q, m_ptr);
      if (w >= 0) begin m_owner = w; m_hold = 1; end
    end else begin
      others = 0;
      for (int k = 0; k < 4; k++) if (k != m_owner && q[k]) others = 1;
      rel = !q[m_owner] || (m_hold == MH && others);
      if (rel) begin
        m_ptr = (m_owner + 1) % 4;
        w = first_from(q, m_ptr);
        if (w >= 0) begin m_owner = w; m_hold = 1; end
        else begin m_owner = -1; m_hold = 0; end
      end else if (m_hold < MH) begin
        m_hold = m_hold + 1;
      end
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the edge.
  task automatic drive(input logic r, input logic [3:0] q);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = q;
    model_step(r, q);
    e.g   = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    e.idx = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    e.v   = (m_owner >= 0);
    e.idl = (m_owner < 0);
    sb_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("grant",       int'(grant),       int'(e.g));
        check("grant_idx",   int'(grant_idx),   int'(e.idx));
        check("grant_valid", int'(grant_valid), int'(e.v));
        check("idle",        int'(idle),        int'(e.idl));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] r_req;

    // Reset dominance with all requests raised.
    repeat (3) drive(1'b1, 4'b1111);

    // Single request, drop, then wrap of the pointer from 3 to 0.
    drive(1'b0, 4'b0100);
    drive(1'b0, 4'b0100);
    drive(1'b0, 4'b0000);
    drive(1'b0, 4'b0101);
    drive(1'b0, 4'b0000);

    // Full contention: each owner held MH cycles, no idle gaps.
    drive(1'b1, 4'b0000);
    repeat (5 * MH + 2) drive(1'b0, 4'b1111);

    // Back-to-back handoff when the owner drops.
    drive(1'b1, 4'b0000);
    drive(1'b0, 4'b0111);
    drive(1'b0, 4'b0111);
    drive(1'b0, 4'b0110);
    drive(1'b0, 4'b0110);

    // Sole requester holds indefinitely, then saturated hold hands off.
    drive(1'b1, 4'b0000);
    repeat (20) drive(1'b0, 4'b1000);
    drive(1'b0, 4'b1010);
    drive(1'b0, 4'b1010);

    // Reset mid-grant: no handoff, restart from pointer 0.
    drive(1'b1, 4'b0000);
    drive(1'b0, 4'b0010);
    drive(1'b0, 4'b1111);
    drive(1'b1, 4'b1111);
    drive(1'b0, 4'b1111);
    drive(1'b0, 4'b1111);

    // MAX_HOLD boundary: owner released exactly after MH cycles under contention.
    drive(1'b1, 4'b0000);
    repeat (MH) drive(1'b0, 4'b0001);
    drive(1'b0, 4'b0011);
    drive(1'b0, 4'b0011);

    // Random traffic with persistent requests and occasional resets.
    r_req = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) r_req[b] = ~r_req[b];
      drive(($urandom_range(0, 150) == 0) ? 1'b1 : 1'b0, r_req);
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time bound in case the clock or stimulus stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got no summary expected summary");
    $fatal(1, "timeout");
  end

endmodule
